line_divider: RTL and testbench
===============================

# line_divider

Parametrised line-pulse divider for the PAL adaptor video timing path. Samples the asynchronous line-sync pulse on the system clock and counts qualified edges modulo `DIVISOR`. Produces:
- a registered half-period square wave;
- a terminal-count strobe;
- a per-line phase toggle for PAL alternation;
- the live count.

A field-sync input realigns the count. Generalises the fixed divide-by-50 LS390 counter into a synchronous, reconfigurable block.

## Interface
Parameters:
- `DIVISOR`, 50: lines per output period; legal range 2..2^WIDTH.
- `HIGH_AT`, 25: count value at which `q` goes high; legal range 1..DIVISOR-1.
- `WIDTH`, 6: counter width; must hold DIVISOR-1.
- `EDGE`, 0: counted edge of `lp`; 0 = falling, 1 = rising.

Ports:
- `cp` in 1: system clock, rising-edge active.
- `mr` in 1: master reset; asynchronous, active-high.
- `lp` in 1: line-sync pulse; asynchronous to `cp` unless sync stage disabled.
- `en` in 1: count enable; edges seen while low are discarded.
- `fs` in 1: field sync, synchronous to `cp`; forces realignment to count 0.
- `q` out 1: high while count ≥ HIGH_AT.
- `tc` out 1: one-`cp` strobe on wrap DIVISOR-1 → 0.
- `phase` out 1: toggles on every counted edge.
- `count` out WIDTH: current line count, 0..DIVISOR-1.

## Operation
- Clock and reset: one clock `cp`. Reset `mr` is asynchronous, active-high.
- Reset values: `count`=0, `q`=0, `tc`=0, `phase`=0.
- Edge-history flops reset to level `EDGE`, so a static `lp` at reset release never produces an edge.
- Edge detection: a qualified edge is a transition of the sampled `lp` to the non-`EDGE` → `EDGE` sense. One `cp` cycle wide.
- Counted edge (edge & `en` & !`fs`):
  - `count` ← (`count` == DIVISOR-1) ? 0 : `count`+1;
  - `phase` toggles.
- Strobe: `tc`=1 for exactly the cycle in which `count` becomes 0 through wrap. Otherwise `tc`=0.
- `q` is registered from the next count value: `q` = (next `count` ≥ HIGH_AT). `q` is therefore always coherent with `count` in the same cycle.
- Field sync: `fs`=1 has priority over an edge in the same cycle.
  - Next cycle: `count`=0, `q`=0, `phase`=0, `tc`=0.
  - The coincident edge is dropped.
- Enable low: `en`=0 holds all outputs. The edge history keeps tracking `lp`, so raising `en` never creates a spurious edge.
- Arithmetic: unsigned, no saturation. Counter never exceeds DIVISOR-1.

## Timing
- Reference point: `lp` transition captured at `cp` rising edge k.
- Output latency: `count`/`q`/`tc`/`phase` update at edge k+1 without sync, k+3 with sync.
- Minimum `lp` high and low time: 2 `cp` periods without sync, 3 with sync. Shorter pulses may be missed but never double-counted.
- `fs` latency: outputs reflect realignment at the edge after `fs` is sampled high.
- Reset mid-count: outputs clear immediately and asynchronously. Counting resumes from 0 on the first qualified edge after `mr` deasserts.

## Configuration
- `LINE_DIVIDER_SYNC_EN` defined: a two-flop synchroniser precedes the edge detector. `lp` may be fully asynchronous. Latency is k+3.
- Not defined: `lp` is treated as synchronous to `cp`. It is registered once for edge history only. Latency is k+1.

## Test plan
- Reset and static input:
  - Stimulus: assert `mr` with `lp`=1, EDGE=0; release and hold `lp` 10 cycles.
  - Response: all outputs 0; no count change.
- Default divide:
  - Stimulus: 100 falling edges of `lp`, 8-cycle period, `en`=1.
  - Response: `q` rises when `count` becomes 25 and falls when `count` wraps to 0. `tc` pulses exactly twice. `phase` ends at 0.
- Field-sync priority:
  - Stimulus: drive to `count`=30 (`q`=1), then assert `fs` in the same cycle as a qualified edge.
  - Response: next cycle `count`=0, `q`=0, `phase`=0, `tc`=0.
- Enable gating:
  - Stimulus: `en`=0 during 5 edges, then raise `en` while `lp` is steady.
  - Response: `count` unchanged; no edge counted on enable rise.
- Parametrised variant:
  - Stimulus: DIVISOR=8, HIGH_AT=2, WIDTH=3, EDGE=1; 8 rising edges.
  - Response: count sequence 1..7,0; `q` high for counts 2..7; one `tc` on the 8th edge.
- Latency check:
  - Stimulus: run with and without `LINE_DIVIDER_SYNC_EN`.
  - Response: `count` increments at edge k+3 and k+1 respectively after `lp` capture.

Source files
------------

// File: rtl/line_divider.sv
// line_divider: divides qualified lp edges modulo DIVISOR and gives q, tc, phase, count.
// Ports: cp, mr (async high), lp, en, fs -> q, tc, phase, count. Option: LINE_DIVIDER_SYNC_EN.
module line_divider #(
  parameter int DIVISOR = 50,
  parameter int HIGH_AT = 25,
  parameter int WIDTH   = 6,
  parameter int EDGE    = 0
) (
  input  logic             cp,
  input  logic             mr,
  input  logic             lp,
  input  logic             en,
  input  logic             fs,
  output logic             q,
  output logic             tc,
  output logic             phase,
  output logic [WIDTH-1:0] count
);

  localparam logic             LVL  = (EDGE != 0);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(DIVISOR - 1);
  localparam logic [WIDTH-1:0] HI   = WIDTH'(HIGH_AT);

  logic lp_in;

`ifdef LINE_DIVIDER_SYNC_EN
  // lp is fully asynchronous here: two-flop synchroniser first.
  logic sy1, sy2;

  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      sy1 <= LVL;
      sy2 <= LVL;
    end else begin
      sy1 <= lp;
      sy2 <= sy1;
    end
  end

  assign lp_in = sy2;
`else
  assign lp_in = lp;
`endif

  // History flops start at the counted level, so a static lp
  // at reset release can never look like a counted edge.
  logic smp, hist;

  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      smp  <= LVL;
      hist <= LVL;
    end else begin
      smp  <= lp_in;
      hist <= smp;
    end
  end

  logic hit;
  assign hit = (smp == LVL) && (hist != LVL);

  logic [WIDTH-1:0] cnt_nxt;
  logic             ph_nxt;
  logic             tc_nxt;
  logic             q_nxt;

  always_comb begin
    cnt_nxt = count;
    ph_nxt  = phase;
    tc_nxt  = 1'b0;
    if (fs) begin
      // realignment wins; a coincident edge is dropped
      cnt_nxt = '0;
      ph_nxt  = 1'b0;
    end else if (hit && en) begin
      if (count == LAST) begin
        cnt_nxt = '0;
        tc_nxt  = 1'b1;
      end else begin
        cnt_nxt = count + WIDTH'(1);
      end
      ph_nxt = ~phase;
    end
    // q follows the next count so it is coherent with count
    q_nxt = (cnt_nxt >= HI);
  end

  always_ff @(posedge cp or posedge mr) begin
    if (mr) begin
      count <= '0;
      q     <= 1'b0;
      tc    <= 1'b0;
      phase <= 1'b0;
    end else begin
      count <= cnt_nxt;
      q     <= q_nxt;
      tc    <= tc_nxt;
      phase <= ph_nxt;
    end
  end

endmodule

// File: tb/tb_line_divider.sv
// tb_line_divider: directed checks of line_divider, default and
// DIVISOR=8 / HIGH_AT=2 / WIDTH=3 / EDGE=1 instances.
module tb_line_divider;

`ifdef LINE_DIVIDER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       cp;
  logic       mr;
  logic       en;
  logic       fs;
  logic       lp_a;
  logic       lp_b;
  logic       q_a, tc_a, ph_a;
  logic [5:0] cnt_a;
  logic       q_b, tc_b, ph_b;
  logic [2:0] cnt_b;

  int checks   = 0;
  int failures = 0;
  int ntc_a    = 0;
  int ntc_b    = 0;

  line_divider u_a (
    .cp(cp), .mr(mr), .lp(lp_a), .en(en), .fs(fs),
    .q(q_a), .tc(tc_a), .phase(ph_a), .count(cnt_a)
  );

  line_divider #(
    .DIVISOR(8), .HIGH_AT(2), .WIDTH(3), .EDGE(1)
  ) u_b (
    .cp(cp), .mr(mr), .lp(lp_b), .en(en), .fs(fs),
    .q(q_b), .tc(tc_b), .phase(ph_b), .count(cnt_b)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge cp);
      if (tc_a === 1'b1) ntc_a++;
      if (tc_b === 1'b1) ntc_b++;
    end
  endtask

  // one falling edge of lp_a, 8-cycle period
  task automatic pulse_a();
    lp_a = 1'b0;
    tick(4);
    lp_a = 1'b1;
    tick(4);
  endtask

  // one rising edge of lp_b, 8-cycle period
  task automatic pulse_b();
    lp_b = 1'b1;
    tick(4);
    lp_b = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    mr = 1'b1;
    tick(2);
    mr = 1'b0;
    tick(3);
  endtask

  initial begin
    int m;
    mr   = 1'b1;
    en   = 1'b1;
    fs   = 1'b0;
    lp_a = 1'b1;
    lp_b = 1'b0;
    tick(3);

    // reset with static lp
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_q", 32'(q_a), 0);
    chk("rst_tc", 32'(tc_a), 0);
    chk("rst_phase", 32'(ph_a), 0);
    chk("rst_b_count", 32'(cnt_b), 0);
    mr = 1'b0;
    tick(10);
    chk("static_count", 32'(cnt_a), 0);
    chk("static_phase", 32'(ph_a), 0);
    chk("static_b_count", 32'(cnt_b), 0);
    chk("static_tc", 32'(ntc_a), 0);

    // latency from capture edge
    lp_a = 1'b0;
    tick(LAT);
    chk("lat_before", 32'(cnt_a), 0);
    tick(1);
    chk("lat_after", 32'(cnt_a), 1);
    tick(3);
    lp_a = 1'b1;
    tick(4);

    // default divide-by-50
    do_reset();
    ntc_a = 0;
    for (int i = 0; i < 100; i++) begin
      pulse_a();
      m = (i + 1) % 50;
      chk("div_count", 32'(cnt_a), 32'(m));
      chk("div_q", 32'(q_a), (m >= 25) ? 1 : 0);
      chk("div_phase", 32'(ph_a), 32'((i + 1) % 2));
    end
    chk("div_tc_pulses", 32'(ntc_a), 2);
    chk("div_phase_end", 32'(ph_a), 0);

    // asynchronous reset mid-count
    for (int i = 0; i < 27; i++) pulse_a();
    chk("mid_pre_count", 32'(cnt_a), 27);
    chk("mid_pre_q", 32'(q_a), 1);
    #2;
    mr = 1'b1;
    #1;
    chk("mid_async_count", 32'(cnt_a), 0);
    chk("mid_async_q", 32'(q_a), 0);
    chk("mid_async_phase", 32'(ph_a), 0);
    tick(2);
    mr = 1'b0;
    tick(3);
    chk("mid_hold", 32'(cnt_a), 0);
    pulse_a();
    chk("mid_resume", 32'(cnt_a), 1);

    // field sync beats a coincident edge
    do_reset();
    ntc_a = 0;
    for (int i = 0; i < 30; i++) pulse_a();
    chk("fs_pre_count", 32'(cnt_a), 30);
    chk("fs_pre_q", 32'(q_a), 1);
    lp_a = 1'b0;
    tick(LAT);
    fs = 1'b1;
    tick(1);
    fs = 1'b0;
    chk("fs_count", 32'(cnt_a), 0);
    chk("fs_q", 32'(q_a), 0);
    chk("fs_phase", 32'(ph_a), 0);
    chk("fs_tc", 32'(tc_a), 0);
    tick(3);
    chk("fs_edge_dropped", 32'(cnt_a), 0);
    lp_a = 1'b1;
    tick(4);

    // enable gating
    for (int i = 0; i < 3; i++) pulse_a();
    chk("en_pre_count", 32'(cnt_a), 3);
    en = 1'b0;
    for (int i = 0; i < 5; i++) pulse_a();
    chk("en_gated_count", 32'(cnt_a), 3);
    chk("en_gated_phase", 32'(ph_a), 1);
    en = 1'b1;
    tick(6);
    chk("en_rise_high", 32'(cnt_a), 3);
    en   = 1'b0;
    lp_a = 1'b0;
    tick(6);
    en = 1'b1;
    tick(6);
    chk("en_rise_low", 32'(cnt_a), 3);
    lp_a = 1'b1;
    tick(4);
    pulse_a();
    chk("en_resume", 32'(cnt_a), 4);
    chk("en_resume_phase", 32'(ph_a), 0);

    // parametrised instance, rising edges, divide by 8
    do_reset();
    ntc_b = 0;
    for (int i = 0; i < 8; i++) begin
      pulse_b();
      m = (i + 1) % 8;
      chk("b_count", 32'(cnt_b), 32'(m));
      chk("b_q", 32'(q_b), (m >= 2) ? 1 : 0);
    end
    chk("b_tc_pulses", 32'(ntc_b), 1);
    chk("b_phase", 32'(ph_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
